lcd_nibble_ctrl: RTL

LCD_NIBBLE_CTRL -- requirements
Module: lcd_nibble_ctrl

---
 rtl/lcd_nibble_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_ctrl.sv
// HD44780-style 4-bit LCD write controller: splits each byte into two E-strobed nibbles.
// Optional power-up init sequence when LCD_INIT_EN is defined.
module lcd_nibble_ctrl #(
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned EXEC_CYC       = 2000,
  parameter int unsigned CLEAR_CYC      = 82000,
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned INIT_LONG_CYC  = 205000
) (
  input  logic       clk,
  input  logic       Clear,
  input  logic       wr_en,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic [3:0] dataout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int unsigned MaxA   = (EXEC_CYC > CLEAR_CYC) ? EXEC_CYC : CLEAR_CYC;
  localparam int unsigned MaxB   = (POWERUP_CYC > INIT_LONG_CYC) ? POWERUP_CYC : INIT_LONG_CYC;
  localparam int unsigned MaxC   = (E_HIGH_CYC > NIBBLE_GAP_CYC) ? E_HIGH_CYC : NIBBLE_GAP_CYC;
  localparam int unsigned MaxAB  = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxAll = (MaxAB > MaxC) ? MaxAB : MaxC;
  localparam int unsigned CntW   = ($clog2(MaxAll) > 20) ? $clog2(MaxAll) : 20;

  localparam logic [CntW-1:0] ELoad     = CntW'(E_HIGH_CYC - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(NIBBLE_GAP_CYC - 1);
  localparam logic [CntW-1:0] ExecLoad  = CntW'(EXEC_CYC - 1);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHiSetup,
    StHiPulse,
    StGap,
    StLoSetup,
    StLoPulse,
    StExecWait
`ifdef LCD_INIT_EN
    , StInit
`endif
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            rs_q;
  logic [7:0]      data_q;
  logic [CntW-1:0] exec_load;
  logic            single_nibble;

  assign LCD_RW = 1'b0;

`ifdef LCD_INIT_EN
  localparam logic [CntW-1:0] PwrLoad  = CntW'(POWERUP_CYC - 1);
  localparam logic [CntW-1:0] LongLoad = CntW'(INIT_LONG_CYC - 1);

  logic       init_active_q;
  logic [2:0] init_idx_q;
  logic       armed_q;
  logic [7:0] init_next;

  // Steps 0..3 are lone high nibbles (0x3,0x3,0x3,0x2); steps 4..7 are full command bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h20;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h06;
      3'd6:             init_byte = 8'h0C;
      default:          init_byte = 8'h01;
    endcase
  endfunction

  assign init_next = init_byte(init_idx_q + 3'd1);
`endif

  always_comb begin
    exec_load     = (!rs_q && data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0) ? ClearLoad : ExecLoad;
    single_nibble = 1'b0;
`ifdef LCD_INIT_EN
    single_nibble = init_active_q && (init_idx_q < 3'd4);
    if (init_active_q && init_idx_q == 3'd0) exec_load = LongLoad;
`endif
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      dataout <= 4'd0;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
`ifdef LCD_INIT_EN
      state_q       <= StInit;
      busy          <= 1'b1;
      init_active_q <= 1'b1;
      init_idx_q    <= 3'd0;
      armed_q       <= 1'b0;
`else
      state_q <= StIdle;
      busy    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_en && !busy) begin
            rs_q    <= wr_rs;
            data_q  <= wr_data;
            LCD_RS  <= wr_rs;
            dataout <= wr_data[7:4];
            busy    <= 1'b1;
            state_q <= StHiSetup;
          end
        end
        StHiSetup: begin
          LCD_E   <= 1'b1;
          cnt_q   <= ELoad;
          state_q <= StHiPulse;
        end
        StHiPulse: begin
          if (cnt_q == '0) begin
            LCD_E <= 1'b0;
            if (single_nibble) begin
              cnt_q   <= exec_load;
              state_q <= StExecWait;
            end else begin
              cnt_q   <= GapLoad;
              state_q <= StGap;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            dataout <= data_q[3:0];
            state_q <= StLoSetup;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StLoSetup: begin
          LCD_E   <= 1'b1;
          cnt_q   <= ELoad;
          state_q <= StLoPulse;
        end
        StLoPulse: begin
          if (cnt_q == '0) begin
            LCD_E   <= 1'b0;
            cnt_q   <= exec_load;
            state_q <= StExecWait;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StExecWait: begin
          if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
            if (init_active_q && init_idx_q != 3'd7) begin
              init_idx_q <= init_idx_q + 3'd1;
              rs_q       <= 1'b0;
              data_q     <= init_next;
              LCD_RS     <= 1'b0;
              dataout    <= init_next[7:4];
              state_q    <= StHiSetup;
            end else begin
              init_active_q <= 1'b0;
              busy          <= 1'b0;
              state_q       <= StIdle;
            end
`else
            busy    <= 1'b0;
            state_q <= StIdle;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef LCD_INIT_EN
        // One arming cycle loads the power-up wait, since Clear leaves the counter at zero.
        StInit: begin
          if (!armed_q) begin
            armed_q <= 1'b1;
            cnt_q   <= PwrLoad;
          end else if (cnt_q == '0) begin
            rs_q    <= 1'b0;
            data_q  <= init_byte(3'd0);
            LCD_RS  <= 1'b0;
            dataout <= 4'h3;
            state_q <= StHiSetup;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
